layer_seq_ctrl: RTL and testbench
=================================

# layer_seq_ctrl

- Sequences one fully-connected layer of `neuron` instances.
- Accepts the previous layer's output as a valid/ready stream and broadcasts each element to all neurons of the layer as an `mInput`/`mInputValid` pulse.
- Collects every neuron's `mOutput` on its `mOutputValid`, then serializes the results in neuron order as a valid/ready stream to the next layer.
- Sits between layer instances in the network top.

## Interface
Parameters:
- `dataWidth`, 16: width of activations and neuron inputs/outputs.
- `numInput`, 10: elements per input vector; equals each neuron's `numWeight`.
- `numNeuron`, 4: neurons in the layer.
- `timeoutCycles`, 1024: maximum WAIT cycles before giving up on missing outputs.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: clock.
- `rstn`, in, 1: asynchronous active-low reset.
- `en`, in, 1: permits starting a new layer pass.
- `sData`, in, `dataWidth`: input element from the previous layer.
- `sValid`, in, 1: `sData` is valid.
- `sReady`, out, 1: controller accepts `sData`.
- `nInput`, out, `dataWidth`: broadcast to every neuron's `mInput`.
- `nInputValid`, out, 1: broadcast to every neuron's `mInputValid`.
- `nOutput`, in, `numNeuron*dataWidth`: neuron i occupies bits `[i*dataWidth +: dataWidth]`.
- `nOutputValid`, in, `numNeuron`: bit i is neuron i's `mOutputValid`.
- `mData`, out, `dataWidth`: serialized layer result.
- `mValid`, out, 1: `mData` is valid.
- `mReady`, in, 1: next layer accepts `mData`.
- `busy`, out, 1: high when state ≠ IDLE.
- `err`, out, 1: sticky timeout flag.

## Operation
States:
- **IDLE**: `sReady`=0, `mValid`=0. Goes to FEED when `en`=1.
- **FEED**: `sReady`=1.
  - On `sValid&sReady`: register `nInput<=sData` and `nInputValid<=1` for exactly one cycle; `inCnt++`.
  - On the beat with `inCnt==numInput-1`: go to WAIT and clear `inCnt`.
  - Gaps in `sValid` produce gaps in `nInputValid`. Neurons must tolerate this.
- **WAIT**: `sReady`=0.
  - Each cycle, for every set bit i of `nOutputValid`, capture slice i into `outBuf[i]` and set `done[i]`.
  - Go to DRAIN when `(done | nOutputValid)` is all ones.
  - `waitCnt` increments every WAIT cycle. When `waitCnt==timeoutCycles-1` and the mask is incomplete: set `err`=1, go to DRAIN. Missing entries stay 0.
  - A neuron that has already captured may pulse again; later values overwrite its entry.
- **DRAIN**:
  - `mValid`=1, `mData=outBuf[outCnt]`.
  - On `mValid&mReady`: `outCnt++`.
  - After beat `numNeuron-1`: clear `outCnt`, `done`, `waitCnt` and `outBuf`. Go to FEED if `en`=1, else IDLE.
  - `mData` must be held stable while `mValid&!mReady`.
- `nOutputValid` outside WAIT is ignored: nothing captured, no flag.
- `en` is sampled only in IDLE and at the end of DRAIN. Deasserting it mid-pass does not abort the pass.
- `err` clears only on reset. It does not block later passes.

## Timing
- Reset values: state IDLE; `sReady`, `nInputValid`, `mValid`, `busy`, `err` = 0; `nInput`, `mData` = 0; all counters, `done`, `outBuf` = 0.
- IDLE→FEED: `sReady` rises in the cycle after `en` is sampled high.
- Input latency: the accept edge produces `nInput`/`nInputValid` valid in the following cycle, one cycle high per beat. Back-to-back accepts give continuous `nInputValid`.
- The last `nInputValid` pulse is issued during the first WAIT cycle.
- WAIT→DRAIN: the cycle after the final `nOutputValid` bit is seen, `mValid`=1. Simultaneous arrival of all bits takes a single capture cycle.
- DRAIN sustains 1 beat/cycle with `mReady`=1. Minimum `numNeuron` cycles.
- Reset asserted in any state: immediate return to the reset values, including mid-FEED or mid-DRAIN. The partial vector is discarded.
- `inCnt`, `outCnt`, `waitCnt` widths: `$clog2` of their limits, minimum 1 bit. No wrap occurs inside a state.

## Structure
- Shared package `nn_ctrl_pkg`:
  - `layer_state_e` enum {IDLE, FEED, WAIT, DRAIN}.
  - Counter-width helper function.
- Sub-module `layer_out_buf`: `numNeuron×dataWidth` capture register file with `done` mask, per-bit capture, clear, and indexed read.
- The FSM and counters stay in `layer_seq_ctrl`.

## Test plan
Defaults: `numInput`=10, `numNeuron`=4, `timeoutCycles`=64.
1. Reset with toggling inputs -> all outputs 0, `busy`=0. `sReady` rises one cycle after `en`=1 following `rstn` release.
2. 10 back-to-back beats of 0x00A4; neurons 3,0,2,1 later return 0x4000,0x1000,0x3000,0x2000 on separate cycles -> 10 consecutive `nInputValid` pulses of 0x00A4, `sReady` low after the 10th accept, `mData` sequence 0x1000,0x2000,0x3000,0x4000, `err`=0.
3. `sValid` every other cycle and `mReady` 1-of-3 cycles -> `nInputValid` gapped identically, exactly 10 pulses, `mData` held stable under stall, 4 beats in order.
4. All four `nOutputValid` bits in the same cycle with 0x0001..0x0004 -> DRAIN next cycle, output 0x0001..0x0004. Any `nOutputValid` pulsed during FEED is not captured.
5. Neuron 2 never valid -> `err`=1 after 64 WAIT cycles, output sequence v0,v1,0x0000,v3. Next pass runs normally with `err` still 1.
6. `rstn` pulsed low mid-WAIT after 2 captures -> state IDLE, `done`=0, `busy`=0. A subsequent full pass produces only the new values.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the layer sequencing controllers.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } layer_state_e;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/layer_out_buf.sv
// Capture register file for one layer's neuron outputs: per-neuron capture
// with a done mask, synchronous bulk clear and an indexed read port.
module layer_out_buf
  import nn_ctrl_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int numNeuron = 4,
  parameter int idxWidth  = cnt_width(numNeuron)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cap_en_i,
  input  logic [numNeuron-1:0]           cap_mask_i,
  input  logic [numNeuron*dataWidth-1:0] cap_data_i,
  input  logic                           clr_i,
  input  logic [idxWidth-1:0]            rd_idx_i,
  output logic [dataWidth-1:0]           rd_data_o,
  output logic [numNeuron-1:0]           done_o
);

  logic [dataWidth-1:0] mem_q [numNeuron];
  logic [numNeuron-1:0] done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q <= '0;
      for (int i = 0; i < numNeuron; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      done_q <= '0;
      for (int i = 0; i < numNeuron; i++) mem_q[i] <= '0;
    end else if (cap_en_i) begin
      // A repeated pulse simply overwrites the earlier value.
      for (int i = 0; i < numNeuron; i++) begin
        if (cap_mask_i[i]) begin
          mem_q[i]  <= cap_data_i[i*dataWidth +: dataWidth];
          done_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < numNeuron; i++) begin
      if (rd_idx_i == idxWidth'(i)) rd_data_o = mem_q[i];
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/layer_seq_ctrl.sv
// Sequences one fully-connected layer: broadcasts an input vector to all
// neurons, gathers their outputs, then streams them out in neuron order.
module layer_seq_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int dataWidth     = 16,
  parameter int numInput      = 10,
  parameter int numNeuron     = 4,
  parameter int timeoutCycles = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           en,
  input  logic [dataWidth-1:0]           sData,
  input  logic                           sValid,
  output logic                           sReady,
  output logic [dataWidth-1:0]           nInput,
  output logic                           nInputValid,
  input  logic [numNeuron*dataWidth-1:0] nOutput,
  input  logic [numNeuron-1:0]           nOutputValid,
  output logic [dataWidth-1:0]           mData,
  output logic                           mValid,
  input  logic                           mReady,
  output logic                           busy,
  output logic                           err
);

  localparam int InW   = cnt_width(numInput);
  localparam int OutW  = cnt_width(numNeuron);
  localparam int WaitW = cnt_width(timeoutCycles);

  localparam logic [InW-1:0]   InLast   = InW'(numInput - 1);
  localparam logic [OutW-1:0]  OutLast  = OutW'(numNeuron - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(timeoutCycles - 1);

  layer_state_e         state_q, state_d;
  logic [InW-1:0]       in_cnt_q, in_cnt_d;
  logic [OutW-1:0]      out_cnt_q, out_cnt_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [dataWidth-1:0] n_input_q, n_input_d;
  logic                 n_input_valid_q, n_input_valid_d;
  logic                 err_q, err_d;

  logic                 buf_cap_en;
  logic                 buf_clr;
  logic [numNeuron-1:0] done_mask;
  logic [dataWidth-1:0] rd_data;
  logic                 all_done;

  layer_out_buf #(
    .dataWidth (dataWidth),
    .numNeuron (numNeuron),
    .idxWidth  (OutW)
  ) u_out_buf (
    .clk        (clk),
    .rstn       (rstn),
    .cap_en_i   (buf_cap_en),
    .cap_mask_i (nOutputValid),
    .cap_data_i (nOutput),
    .clr_i      (buf_clr),
    .rd_idx_i   (out_cnt_q),
    .rd_data_o  (rd_data),
    .done_o     (done_mask)
  );

  // Outputs arriving in the same cycle as the last missing one count too.
  assign all_done   = &(done_mask | nOutputValid);
  assign buf_cap_en = (state_q == WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      in_cnt_q        <= '0;
      out_cnt_q       <= '0;
      wait_cnt_q      <= '0;
      n_input_q       <= '0;
      n_input_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      in_cnt_q        <= in_cnt_d;
      out_cnt_q       <= out_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      n_input_q       <= n_input_d;
      n_input_valid_q <= n_input_valid_d;
      err_q           <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    in_cnt_d        = in_cnt_q;
    out_cnt_d       = out_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    n_input_d       = n_input_q;
    n_input_valid_d = 1'b0;
    err_d           = err_q;
    buf_clr         = 1'b0;
    sReady          = 1'b0;
    mValid          = 1'b0;
    mData           = '0;

    case (state_q)
      IDLE: begin
        if (en) state_d = FEED;
      end
      FEED: begin
        sReady = 1'b1;
        if (sValid) begin
          n_input_d       = sData;
          n_input_valid_d = 1'b1;
          if (in_cnt_q == InLast) begin
            in_cnt_d = '0;
            state_d  = WAIT;
          end else begin
            in_cnt_d = in_cnt_q + InW'(1);
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
        if (all_done) begin
          state_d = DRAIN;
        end else if (wait_cnt_q == WaitLast) begin
          // Give up on the missing neurons; their entries drain as zero.
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        mValid = 1'b1;
        mData  = rd_data;
        if (mReady) begin
          if (out_cnt_q == OutLast) begin
            out_cnt_d  = '0;
            wait_cnt_d = '0;
            buf_clr    = 1'b1;
            state_d    = en ? FEED : IDLE;
          end else begin
            out_cnt_d = out_cnt_q + OutW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign nInput      = n_input_q;
  assign nInputValid = n_input_valid_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl with hand-computed expectations.
module tb_layer_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [15:0] sData;
  logic        sValid;
  logic        sReady;
  logic [15:0] nInput;
  logic        nInputValid;
  logic [63:0] nOutput;
  logic [3:0]  nOutputValid;
  logic [15:0] mData;
  logic        mValid;
  logic        mReady;
  logic        busy;
  logic        err;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Monitor state
  int          nv_cnt = 0, nv_first = 0, nv_last = 0, nv_bad = 0;
  logic [15:0] nv_exp = '0;
  logic [15:0] beats[$];
  int          stable_bad = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_mdata = '0;
  int          c_acc;

  layer_seq_ctrl #(
    .dataWidth     (16),
    .numInput      (10),
    .numNeuron     (4),
    .timeoutCycles (64)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .sData        (sData),
    .sValid       (sValid),
    .sReady       (sReady),
    .nInput       (nInput),
    .nInputValid  (nInputValid),
    .nOutput      (nOutput),
    .nOutputValid (nOutputValid),
    .mData        (mData),
    .mValid       (mValid),
    .mReady       (mReady),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (nInputValid) begin
      if (nv_cnt == 0) nv_first = cyc;
      nv_last = cyc;
      nv_cnt++;
      if (nInput !== nv_exp) nv_bad++;
    end
    if (mValid && mReady) beats.push_back(mData);
    if (mValid && prev_stall && (mData !== prev_mdata)) stable_bad++;
    prev_stall = mValid && !mReady;
    prev_mdata = mData;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon(input logic [15:0] exp_data);
    nv_cnt = 0; nv_first = 0; nv_last = 0; nv_bad = 0;
    nv_exp = exp_data;
  endtask

  // Sends 10 beats of d; gap inserts one idle cycle between beats.
  task automatic send_vec(input logic [15:0] d, input int gap, input string tag);
    for (int i = 0; i < 10; i++) begin
      bit rdy;
      rdy = 1'b0;
      sData  = d;
      sValid = 1'b1;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (sReady) begin
          rdy = 1'b1;
          break;
        end
      end
      if (!rdy) begin
        chk({tag, "_sready_timeout"}, 32'(rdy), 32'd1);
        sValid = 1'b0;
        return;
      end
      tick();
      sValid = 1'b0;
      if (gap != 0 && i < 9) tick();
    end
  endtask

  task automatic pulse(input int idx, input logic [15:0] v);
    nOutput = '0;
    nOutput[idx*16 +: 16] = v;
    nOutputValid = 4'b0001 << idx;
    tick();
    nOutputValid = '0;
  endtask

  task automatic pulse_all(input logic [15:0] v0, v1, v2, v3);
    nOutput = {v3, v2, v1, v0};
    nOutputValid = 4'hF;
    tick();
    nOutputValid = '0;
  endtask

  task automatic drain(input int period, input logic [15:0] e0, e1, e2, e3, input string tag);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    beats.delete();
    stable_bad = 0;
    for (int k = 0; k < 400 && beats.size() < 4; k++) begin
      mReady = (k % period == 0);
      tick();
    end
    mReady = 1'b0;
    chk({tag, "_beats"}, beats.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_mdata"}, (i < beats.size()) ? beats[i] : 16'hxxxx, e[i]);
    chk({tag, "_stable"}, stable_bad, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; sData = '0; sValid = 1'b0;
    nOutput = '0; nOutputValid = '0; mReady = 1'b0;

    // 1: reset holds outputs low while inputs toggle
    for (int k = 0; k < 4; k++) begin
      sValid       = k[0];
      nOutputValid = k[0] ? 4'hF : 4'h0;
      nOutput      = {4{16'h5A5A}};
      mReady       = ~k[0];
      en           = k[0];
      sData        = 16'h1234 + 16'(k);
      @(negedge clk);
      chk("rst_ctrl", {27'd0, sReady, nInputValid, mValid, busy, err}, 32'd0);
      chk("rst_data", {nInput, mData}, 32'd0);
      tick();
    end
    sValid = 1'b0; nOutputValid = '0; mReady = 1'b0; en = 1'b0; nOutput = '0;
    rstn = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("idle_sready", 32'(sReady), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    en = 1'b1;
    @(negedge clk);
    chk("en_not_yet_sampled", 32'(sReady), 32'd0);
    tick();
    @(negedge clk);
    chk("feed_sready", 32'(sReady), 32'd1);
    chk("feed_busy", 32'(busy), 32'd1);
    tick();

    // 2: back-to-back feed, outputs on separate cycles
    clear_mon(16'h00A4);
    send_vec(16'h00A4, 0, "s2");
    @(negedge clk);
    chk("s2_sready_low", 32'(sReady), 32'd0);
    chk("s2_last_nvalid_in_wait", 32'(nInputValid), 32'd1);
    tick();
    pulse(3, 16'h4000); tick();
    pulse(0, 16'h1000); tick();
    pulse(2, 16'h3000); tick();
    @(negedge clk);
    chk("s2_still_waiting", 32'(mValid), 32'd0);
    tick();
    pulse(1, 16'h2000);
    @(negedge clk);
    chk("s2_drain_next_cycle", 32'(mValid), 32'd1);
    chk("s2_nv_count", nv_cnt, 32'd10);
    chk("s2_nv_span", nv_last - nv_first, 32'd9);
    chk("s2_nv_data", nv_bad, 32'd0);
    drain(1, 16'h1000, 16'h2000, 16'h3000, 16'h4000, "s2");
    chk("s2_err", 32'(err), 32'd0);

    // 3: gapped input, stalled output
    clear_mon(16'h0055);
    send_vec(16'h0055, 1, "s3");
    tick();
    pulse(1, 16'h0B00); pulse(3, 16'h0D00); pulse(0, 16'h0A00); pulse(2, 16'h0C00);
    chk("s3_nv_count", nv_cnt, 32'd10);
    chk("s3_nv_span", nv_last - nv_first, 32'd18);
    chk("s3_nv_data", nv_bad, 32'd0);
    drain(3, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, "s3");

    // 4: junk outputs during FEED ignored; all outputs in one cycle; en dropped mid-pass
    pulse_all(16'hBAD0, 16'hBAD1, 16'hBAD2, 16'hBAD3);
    clear_mon(16'h0777);
    send_vec(16'h0777, 0, "s4");
    en = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("s4_no_feed_capture", 32'(mValid), 32'd0);
    tick();
    pulse_all(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    @(negedge clk);
    chk("s4_drain_next_cycle", 32'(mValid), 32'd1);
    drain(1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, "s4");
    @(negedge clk);
    chk("s4_idle_busy", 32'(busy), 32'd0);
    chk("s4_idle_sready", 32'(sReady), 32'd0);
    tick();
    en = 1'b1;

    // 5: neuron 2 never answers
    clear_mon(16'h0123);
    send_vec(16'h0123, 0, "s5");
    c_acc = cyc;
    @(negedge clk);
    chk("s5_err_before", 32'(err), 32'd0);
    tick();
    pulse(0, 16'h0111); pulse(1, 16'h0222); pulse(3, 16'h0444);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mValid) break;
    end
    chk("s5_timeout_cycles", cyc - c_acc, 32'd64);
    chk("s5_err_set", 32'(err), 32'd1);
    tick();
    drain(1, 16'h0111, 16'h0222, 16'h0000, 16'h0444, "s5");
    clear_mon(16'h0321);
    send_vec(16'h0321, 0, "s5b");
    tick();
    pulse(2, 16'h0E03); pulse(0, 16'h0E01); pulse(3, 16'h0E04); pulse(1, 16'h0E02);
    drain(1, 16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04, "s5b");
    chk("s5b_err_sticky", 32'(err), 32'd1);

    // 6: reset mid-WAIT discards the partial pass
    clear_mon(16'h0999);
    send_vec(16'h0999, 0, "s6");
    tick();
    pulse(0, 16'hDEAD); pulse(1, 16'hBEEF);
    rstn = 1'b0;
    #1;
    chk("s6_rst_ctrl", {28'd0, sReady, mValid, busy, err}, 32'd0);
    tick();
    rstn = 1'b1;
    send_vec(16'h0888, 0, "s6b");
    tick();
    pulse(2, 16'h0C03); pulse(3, 16'h0D04);
    tick();
    @(negedge clk);
    chk("s6_done_cleared", 32'(mValid), 32'd0);
    tick();
    pulse(0, 16'h0A01); pulse(1, 16'h0B02);
    drain(1, 16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04, "s6");
    chk("s6_err_cleared", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
